// File: rtl/ddc_frame_reader_if.sv
// Converter-side and frame-side signals of the DDC serial frame reader.
// The reader attaches through the slave modport; the driving side uses master.
interface ddc_frame_reader_if #(
  parameter int unsigned FRAME_BITS = 40
);
  logic                  enable;
  logic                  DVALID_BAR;
  logic                  DCLK;
  logic                  DOUT;
  logic                  CONV;
  logic                  DXMIT_BAR;
  logic [FRAME_BITS-1:0] frame;
  logic                  frame_side;
  logic                  frame_valid;
  logic [15:0]           frame_cnt;
  logic                  overrun;
  logic                  timeout_err;

  modport master (
    output enable, DVALID_BAR, DCLK, DOUT, CONV,
    input  DXMIT_BAR, frame, frame_side, frame_valid, frame_cnt, overrun, timeout_err
  );

  modport slave (
    input  enable, DVALID_BAR, DCLK, DOUT, CONV,
    output DXMIT_BAR, frame, frame_side, frame_valid, frame_cnt, overrun, timeout_err
  );
endinterface

// File: rtl/ddc_frame_reader.sv
// Serial readout of the DDC converter: requests transmission, shifts in DOUT on
// synchronized DCLK rising edges and presents each complete frame in parallel.
module ddc_frame_reader #(
  parameter int unsigned WORD_BITS   = 20,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input logic               clk,
  input logic               reset_n,
  ddc_frame_reader_if.slave bus
);
  localparam int unsigned FRAME_BITS = WORD_BITS * NUM_CH;
  localparam int unsigned BCNT_W     = $clog2(FRAME_BITS + 1);
  localparam int unsigned TCNT_W     = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, ABORT} state_t;

  state_t                state;
  logic [2:0]            dv_q;
  logic [2:0]            dclk_q;
  logic [1:0]            dout_q;
  logic [1:0]            conv_q;
  logic [BCNT_W-1:0]     bcnt;
  logic [TCNT_W-1:0]     tcnt;
  logic [FRAME_BITS-1:0] shift_r;
  logic                  side_r;
  logic                  dxmit_bar_r;
  logic [FRAME_BITS-1:0] frame_r;
  logic                  frame_side_r;
  logic                  frame_valid_r;
  logic [15:0]           frame_cnt_r;
  logic                  overrun_r;
  logic                  timeout_err_r;

  // Edges are taken between the second sync stage and a third registered copy
  logic dv_fall;
  logic dclk_rise;
  assign dv_fall   = dv_q[2] & ~dv_q[1];
  assign dclk_rise = ~dclk_q[2] & dclk_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dv_q          <= '1;
      dclk_q        <= '0;
      dout_q        <= '0;
      conv_q        <= '1;
      state         <= IDLE;
      bcnt          <= '0;
      tcnt          <= '0;
      shift_r       <= '0;
      side_r        <= 1'b0;
      dxmit_bar_r   <= 1'b1;
      frame_r       <= '0;
      frame_side_r  <= 1'b0;
      frame_valid_r <= 1'b0;
      frame_cnt_r   <= '0;
      overrun_r     <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      dv_q          <= {dv_q[1:0], bus.DVALID_BAR};
      dclk_q        <= {dclk_q[1:0], bus.DCLK};
      dout_q        <= {dout_q[0], bus.DOUT};
      conv_q        <= {conv_q[0], bus.CONV};
      frame_valid_r <= 1'b0;
      timeout_err_r <= 1'b0;
      // A new data-ready while a frame is in flight is reported and dropped
      overrun_r     <= dv_fall && (state != IDLE);

      case (state)
        IDLE: begin
          if (dv_fall && bus.enable) begin
            side_r      <= conv_q[1];
            bcnt        <= '0;
            tcnt        <= '0;
            dxmit_bar_r <= 1'b0;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          if (dclk_rise) begin
            shift_r <= {shift_r[FRAME_BITS-2:0], dout_q[1]};
            bcnt    <= bcnt + BCNT_W'(1);
            tcnt    <= '0;
            if (bcnt == BCNT_W'(FRAME_BITS - 1)) begin
              state <= DONE;
            end
          end else if (tcnt == TCNT_W'(TIMEOUT_CYC - 1)) begin
            state <= ABORT;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        DONE: begin
          frame_r       <= shift_r;
          frame_side_r  <= side_r;
          frame_valid_r <= 1'b1;
          frame_cnt_r   <= frame_cnt_r + 16'd1;
          dxmit_bar_r   <= 1'b1;
          state         <= IDLE;
        end
        ABORT: begin
          dxmit_bar_r   <= 1'b1;
          timeout_err_r <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.DXMIT_BAR   = dxmit_bar_r;
  assign bus.frame       = frame_r;
  assign bus.frame_side  = frame_side_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.frame_cnt   = frame_cnt_r;
  assign bus.overrun     = overrun_r;
  assign bus.timeout_err = timeout_err_r;
endmodule
